// File: rtl/cache_port_arbiter.sv
// Shares one single-ported data cache between instruction fetch (port 0) and the LSU (port 1).
// Define CACHE_PORT_ARB_RR_EN for round-robin arbitration; otherwise port 1 has fixed priority.
//
// state | meaning
// IDLE  | sample requests, pick a winner, launch cache_enable
// ISSUE | cache_enable high for this single cycle
// WAIT  | hold request to cache until cache_available
// RESP  | done pulse to the winner is visible
module cache_port_arbiter #(
  parameter int ADDR_W = 27,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              write0,
  output logic              done0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              write1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] cache_addr,
  output logic [DATA_W-1:0] cache_write_data,
  output logic              cache_write,
  output logic              cache_enable,
  input  logic [DATA_W-1:0] cache_read_data,
  input  logic              cache_available,
  output logic              busy,
  output logic              grant_id
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic [ADDR_W-1:0] cache_addr_q, cache_addr_d;
  logic [DATA_W-1:0] cache_write_data_q, cache_write_data_d;
  logic              cache_write_q, cache_write_d;
  logic              cache_enable_q, cache_enable_d;
  logic              grant_id_q, grant_id_d;
  logic              winner;

`ifdef CACHE_PORT_ARB_RR_EN
  logic rr_last_q, rr_last_d;

  // Contention goes to the port that did not win last; a lone requester always wins.
  always_comb winner = (req0 && req1) ? ~rr_last_q : req1;
`else
  always_comb winner = req1;
`endif

  always_comb begin
    state_d            = state_q;
    done0_d            = 1'b0;
    done1_d            = 1'b0;
    rdata0_d           = rdata0_q;
    rdata1_d           = rdata1_q;
    cache_addr_d       = cache_addr_q;
    cache_write_data_d = cache_write_data_q;
    cache_write_d      = cache_write_q;
    cache_enable_d     = 1'b0;
    grant_id_d         = grant_id_q;
`ifdef CACHE_PORT_ARB_RR_EN
    rr_last_d          = rr_last_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          grant_id_d         = winner;
          cache_addr_d       = winner ? addr1  : addr0;
          cache_write_data_d = winner ? wdata1 : wdata0;
          cache_write_d      = winner ? write1 : write0;
          cache_enable_d     = 1'b1;
`ifdef CACHE_PORT_ARB_RR_EN
          rr_last_d          = winner;
`endif
          state_d            = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (cache_available) begin
          if (!cache_write_q) begin
            if (grant_id_q) rdata1_d = cache_read_data;
            else            rdata0_d = cache_read_data;
          end
          if (grant_id_q) done1_d = 1'b1;
          else            done0_d = 1'b1;
          state_d = S_RESP;
        end
      end
      // RESP always returns to IDLE so a requester gets one edge to drop req after done.
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q            <= S_IDLE;
      done0_q            <= 1'b0;
      done1_q            <= 1'b0;
      rdata0_q           <= '0;
      rdata1_q           <= '0;
      cache_addr_q       <= '0;
      cache_write_data_q <= '0;
      cache_write_q      <= 1'b0;
      cache_enable_q     <= 1'b0;
      grant_id_q         <= 1'b0;
`ifdef CACHE_PORT_ARB_RR_EN
      rr_last_q          <= 1'b1;
`endif
    end else begin
      state_q            <= state_d;
      done0_q            <= done0_d;
      done1_q            <= done1_d;
      rdata0_q           <= rdata0_d;
      rdata1_q           <= rdata1_d;
      cache_addr_q       <= cache_addr_d;
      cache_write_data_q <= cache_write_data_d;
      cache_write_q      <= cache_write_d;
      cache_enable_q     <= cache_enable_d;
      grant_id_q         <= grant_id_d;
`ifdef CACHE_PORT_ARB_RR_EN
      rr_last_q          <= rr_last_d;
`endif
    end
  end

  assign done0            = done0_q;
  assign done1            = done1_q;
  assign rdata0           = rdata0_q;
  assign rdata1           = rdata1_q;
  assign cache_addr       = cache_addr_q;
  assign cache_write_data = cache_write_data_q;
  assign cache_write      = cache_write_q;
  assign cache_enable     = cache_enable_q;
  assign grant_id         = grant_id_q;
  assign busy             = (state_q != S_IDLE);

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Bench for cache_port_arbiter: behavioural cache with hit/miss latency plus a
// transaction-level model of arbitration, memory contents and per-port read data.
module tb_cache_port_arbiter;
  localparam int ADDR_W = 27;
  localparam int DATA_W = 32;

  logic              clk, rstn;
  logic              req0, write0, done0, req1, write1, done1;
  logic [ADDR_W-1:0] addr0, addr1, cache_addr;
  logic [DATA_W-1:0] wdata0, wdata1, rdata0, rdata1, cache_write_data, cache_read_data;
  logic              cache_write, cache_enable, cache_available, busy, grant_id;
  logic              model_avail, inject_avail;

  int checks = 0;
  int failures = 0;
  int n_en = 0;
  int n_done = 0;
  int lat_mode = 0;
  int rr_last_m = 1;
  logic [DATA_W-1:0] ref_rdata [2];
  logic [DATA_W-1:0] cmem [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];
  int cnt = 0;
  logic [ADDR_W-1:0] c_addr;
  logic c_wr;

  cache_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rstn(rstn),
    .req0(req0), .addr0(addr0), .wdata0(wdata0), .write0(write0), .done0(done0), .rdata0(rdata0),
    .req1(req1), .addr1(addr1), .wdata1(wdata1), .write1(write1), .done1(done1), .rdata1(rdata1),
    .cache_addr(cache_addr), .cache_write_data(cache_write_data), .cache_write(cache_write),
    .cache_enable(cache_enable), .cache_read_data(cache_read_data),
    .cache_available(cache_available), .busy(busy), .grant_id(grant_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign cache_available = model_avail | inject_avail;

  function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
    return {5'h15, a} ^ 32'h0F0F_3C3C;
  endfunction

  function automatic logic [DATA_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic int pick_lat();
    case (lat_mode)
      0:       return 2;
      1:       return 20;
      default: return ($urandom_range(0, 2) == 0) ? int'($urandom_range(3, 10)) : 2;
    endcase
  endfunction

  // Winner rule from the arbitration policy; remembers the last winner for round-robin.
  function automatic int arb(input bit r0, input bit r1);
    int w;
    if (r0 && r1) begin
`ifdef CACHE_PORT_ARB_RR_EN
      w = 1 - rr_last_m;
`else
      w = 1;
`endif
    end else begin
      w = r1 ? 1 : 0;
    end
    rr_last_m = w;
    return w;
  endfunction

  function automatic logic get_done(input int p);
    return (p == 1) ? done1 : done0;
  endfunction

  function automatic logic [DATA_W-1:0] get_rdata(input int p);
    return (p == 1) ? rdata1 : rdata0;
  endfunction

  // Cache: available pulses (lat) cycles after the enable cycle; garbage on read_data otherwise.
  always @(negedge clk) begin
    model_avail = 1'b0;
    cache_read_data = $urandom;
    if (!rstn) begin
      cnt = 0;
    end else begin
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          model_avail = 1'b1;
          if (!c_wr) cache_read_data = cmem.exists(c_addr) ? cmem[c_addr] : init_val(c_addr);
        end
      end
      if (cache_enable) begin
        c_addr = cache_addr;
        c_wr   = cache_write;
        if (cache_write) cmem[cache_addr] = cache_write_data;
        cnt = pick_lat();
      end
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      n_en   += int'(cache_enable);
      n_done += int'(done0) + int'(done1);
    end
  end

  task automatic do_reset();
    rstn = 1'b0;
    req0 = 1'b0; req1 = 1'b0; write0 = 1'b0; write1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    inject_avail = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    rr_last_m = 1;
    ref_rdata[0] = '0;
    ref_rdata[1] = '0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({done0, done1, cache_enable, cache_write, busy, grant_id} !== 6'b0)
      $display("FAIL reset_ctrl got=%b exp=000000", {done0, done1, cache_enable, cache_write, busy, grant_id});
    checks++;
    if ({cache_addr, cache_write_data, rdata0, rdata1} !== '0)
      $display("FAIL reset_data got addr=%h wd=%h r0=%h r1=%h exp=0", cache_addr, cache_write_data, rdata0, rdata1);
  endtask

  task automatic test_hit_load();
    lat_mode = 0;
    cmem[27'h10] = 32'hDEADBEEF;
    ref_mem[27'h10] = 32'hDEADBEEF;
    req0 = 1'b1; addr0 = 27'h10; write0 = 1'b0; wdata0 = $urandom;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if (cache_enable !== (c == 1)) begin
        failures++;
        $display("FAIL hit_enable cycle=%0d got=%b exp=%b", c, cache_enable, (c == 1));
      end
      if (c == 1) begin
        checks++;
        if ({cache_addr, cache_write, grant_id} !== {27'h10, 1'b0, 1'b0}) begin
          failures++;
          $display("FAIL hit_issue got addr=%h wr=%b gid=%b exp addr=10 wr=0 gid=0", cache_addr, cache_write, grant_id);
        end
      end
      checks++;
      if ({done0, done1} !== {(c == 4), 1'b0}) begin
        failures++;
        $display("FAIL hit_done cycle=%0d got=%b%b exp=%b0", c, done0, done1, (c == 4));
      end
    end
    checks++;
    if (rdata0 !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL hit_rdata0 got=%h exp=deadbeef", rdata0);
    end
    ref_rdata[0] = 32'hDEADBEEF;
    req0 = 1'b0;
    @(negedge clk);
    checks++;
    if ({done0, busy} !== 2'b00) begin
      failures++;
      $display("FAIL hit_after got done0=%b busy=%b exp 0 0", done0, busy);
    end
  endtask

  task automatic test_store_miss();
    int c = 0;
    int ndone1 = 0;
    int ndone0 = 0;
    int done_at = -1;
    int en_start = n_en;
    lat_mode = 1;
    req1 = 1'b1; addr1 = 27'h24; wdata1 = 32'h12345678; write1 = 1'b1;
    while (c < 30) begin
      @(negedge clk);
      c++;
      ndone1 += int'(done1);
      ndone0 += int'(done0);
      if (done1 && done_at < 0) begin
        done_at = c;
        req1 = 1'b0; write1 = 1'b0;
      end
      if (c >= 2 && done_at < 0) begin
        checks++;
        if ({cache_write, cache_write_data, cache_addr} !== {1'b1, 32'h12345678, 27'h24}) begin
          failures++;
          $display("FAIL miss_hold cycle=%0d got wr=%b wd=%h addr=%h exp 1 12345678 24", c, cache_write, cache_write_data, cache_addr);
        end
      end
    end
    ref_mem[27'h24] = 32'h12345678;
    checks++;
    if (done_at != 22) begin
      failures++;
      $display("FAIL miss_latency got=%0d exp=22", done_at);
    end
    checks++;
    if (ndone1 != 1 || ndone0 != 0 || (n_en - en_start) != 1) begin
      failures++;
      $display("FAIL miss_pulses got done1=%0d done0=%0d en=%0d exp 1 0 1", ndone1, ndone0, n_en - en_start);
    end
    checks++;
    if (rdata1 !== ref_rdata[1]) begin
      failures++;
      $display("FAIL miss_rdata1 got=%h exp=%h", rdata1, ref_rdata[1]);
    end
  endtask

  task automatic test_arbitration();
    int w;
    bit got;
    do_reset();
    lat_mode = 0;
    req0 = 1'b1; req1 = 1'b1; addr0 = 27'h40; addr1 = 27'h44; write0 = 1'b0; write1 = 1'b0;
    for (int t = 0; t < 4; t++) begin
      w = arb(1'b1, 1'b1);
      got = 1'b0;
      for (int g = 0; g < 20 && !got; g++) begin
        @(negedge clk);
        got = done0 | done1;
      end
      if (t == 3) begin
        req0 = 1'b0; req1 = 1'b0;
      end
      checks++;
      if (!got || get_done(w) !== 1'b1 || get_done(1 - w) !== 1'b0 || grant_id !== 1'(w)) begin
        failures++;
        $display("FAIL arb_grant txn=%0d got done0=%b done1=%b gid=%b exp port=%0d", t, done0, done1, grant_id, w);
      end
      ref_rdata[w] = ref_read(w == 1 ? 27'h44 : 27'h40);
      checks++;
      if (get_rdata(w) !== ref_rdata[w]) begin
        failures++;
        $display("FAIL arb_rdata txn=%0d got=%h exp=%h", t, get_rdata(w), ref_rdata[w]);
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, cache_enable} !== 2'b00) begin
      failures++;
      $display("FAIL arb_idle got busy=%b en=%b exp 0 0", busy, cache_enable);
    end
  endtask

  task automatic test_reset_mid();
    int nd = 0;
    lat_mode = 1;
    req1 = 1'b1; addr1 = 27'h7FF0000; wdata1 = 32'hCAFEF00D; write1 = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, cache_write, grant_id} !== 3'b111) begin
      failures++;
      $display("FAIL mid_wait got busy=%b wr=%b gid=%b exp 1 1 1", busy, cache_write, grant_id);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({done0, done1, cache_enable, cache_write, busy, grant_id} !== 6'b0 ||
        {cache_addr, cache_write_data, rdata0, rdata1} !== '0) begin
      failures++;
      $display("FAIL mid_async got ctl=%b addr=%h wd=%h r0=%h r1=%h exp all 0",
               {done0, done1, cache_enable, cache_write, busy, grant_id}, cache_addr, cache_write_data, rdata0, rdata1);
    end
    req1 = 1'b0; write1 = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    rr_last_m = 1;
    ref_rdata[0] = '0;
    ref_rdata[1] = '0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      nd += int'(done0) + int'(done1) + int'(busy);
      if (c == 5) inject_avail = 1'b1;
      if (c == 6) inject_avail = 1'b0;
    end
    checks++;
    if (nd != 0) begin
      failures++;
      $display("FAIL mid_no_done got=%0d exp=0", nd);
    end
  endtask

  task automatic test_stray_available();
    lat_mode = 0;
    inject_avail = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      inject_avail = 1'b0;
      checks++;
      if ({done0, done1, busy, cache_enable} !== 4'b0) begin
        failures++;
        $display("FAIL stray_idle cycle=%0d got=%b exp=0000", c, {done0, done1, busy, cache_enable});
      end
    end
    req0 = 1'b1; addr0 = 27'h10; write0 = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      inject_avail = (c == 1) || (c == 4);
      if (c == 4) req0 = 1'b0;
      checks++;
      if ({done0, done1} !== {(c == 4), 1'b0}) begin
        failures++;
        $display("FAIL stray_busy cycle=%0d got=%b%b exp=%b0", c, done0, done1, (c == 4));
      end
    end
    inject_avail = 1'b0;
    ref_rdata[0] = ref_read(27'h10);
    checks++;
    if (rdata0 !== ref_rdata[0] || busy !== 1'b0) begin
      failures++;
      $display("FAIL stray_result got r0=%h busy=%b exp %h 0", rdata0, busy, ref_rdata[0]);
    end
  endtask

  task automatic test_random();
    bit pend [2];
    logic [ADDR_W-1:0] pa [2];
    logic [DATA_W-1:0] pw [2];
    bit pwr [2];
    logic [DATA_W-1:0] exp_d;
    int served = 0;
    int en0 = n_en;
    int dn0 = n_done;
    int w, o;
    bit got;
    lat_mode = 2;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; pa[p] = '0; pw[p] = '0; pwr[p] = 1'b0;
    end
    while (served < 100) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 3) != 0) begin
          pend[p] = 1'b1;
          pa[p]   = 27'(32'h100 + 4 * $urandom_range(0, 7));
          pw[p]   = $urandom;
          pwr[p]  = ($urandom_range(0, 1) == 1);
        end
      end
      req0 = pend[0]; addr0 = pa[0]; wdata0 = pw[0]; write0 = pwr[0];
      req1 = pend[1]; addr1 = pa[1]; wdata1 = pw[1]; write1 = pwr[1];
      if (!pend[0] && !pend[1]) begin
        @(negedge clk);
        continue;
      end
      w = arb(pend[0], pend[1]);
      o = 1 - w;
      got = 1'b0;
      for (int g = 0; g < 40 && !got; g++) begin
        @(negedge clk);
        got = done0 | done1;
      end
      checks++;
      if (!got) begin
        failures++;
        $display("FAIL rnd_timeout txn=%0d got no done exp done on port %0d", served, w);
        break;
      end
      checks++;
      if (get_done(w) !== 1'b1 || get_done(o) !== 1'b0 || grant_id !== 1'(w)) begin
        failures++;
        $display("FAIL rnd_grant txn=%0d got done0=%b done1=%b gid=%b exp port=%0d", served, done0, done1, grant_id, w);
      end
      if (!pwr[w]) begin
        exp_d = ref_read(pa[w]);
        checks++;
        if (get_rdata(w) !== exp_d) begin
          failures++;
          $display("FAIL rnd_rdata txn=%0d port=%0d got=%h exp=%h", served, w, get_rdata(w), exp_d);
        end
        ref_rdata[w] = exp_d;
      end else begin
        ref_mem[pa[w]] = pw[w];
      end
      checks++;
      if (get_rdata(o) !== ref_rdata[o]) begin
        failures++;
        $display("FAIL rnd_other_rdata txn=%0d port=%0d got=%h exp=%h", served, o, get_rdata(o), ref_rdata[o]);
      end
      pend[w] = 1'b0;
      served++;
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ((n_en - en0) != served || (n_done - dn0) != served) begin
      failures++;
      $display("FAIL rnd_counts got en=%0d done=%0d exp %0d each", n_en - en0, n_done - dn0, served);
    end
  endtask

  initial begin
    test_reset();
    test_hit_load();
    test_store_miss();
    test_arbitration();
    test_reset_mid();
    test_stray_available();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit reached");
  end

endmodule

// File: doc/cache_port_arbiter.md
Name: cache_port_arbiter

Overview:
- Shares the single-ported write-back data cache between two requesters: port 0 (instruction fetch) and port 1 (load/store unit).
- Accepts level-held requests and issues exactly one single-cycle cache_enable per transaction.
- Waits for the cache's one-cycle available pulse, then returns read data and a one-cycle done pulse to the winner.
- Sits between the core front-end/LSU and the cache; the cache's DDR2 side is untouched.

Parameters:
ADDR_W, 27, byte address width (matches cache addr)
DATA_W, 32, word width (matches cache read/write data)

Ports:
clk  in  1  system clock, all logic on rising edge
rstn  in  1  asynchronous active-low reset
req0  in  1  port 0 request, held high until done0
addr0  in  ADDR_W  port 0 byte address, stable while req0
wdata0  in  DATA_W  port 0 write data
write0  in  1  port 0: 1 = store, 0 = load
done0  out  1  one-cycle completion pulse for port 0
rdata0  out  DATA_W  port 0 load data, valid with done0, held until next port-0 done
req1/addr1/wdata1/write1/done1/rdata1  same as port 0, for port 1
cache_addr  out  ADDR_W  to cache addr
cache_write_data  out  DATA_W  to cache write_data
cache_write  out  1  to cache write
cache_enable  out  1  to cache enable, one-cycle pulse
cache_read_data  in  DATA_W  from cache read_data
cache_available  in  1  from cache available, one-cycle pulse
busy  out  1  high in any state other than IDLE
grant_id  out  1  port of the current/last transaction

Behaviour:
- Reset (rstn=0, async): state=IDLE; done0=done1=0; cache_enable=0; cache_write=0; cache_addr, cache_write_data, rdata0, rdata1 = 0; grant_id=0; rr_last=1.
- FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE, no req: stay in IDLE.
- IDLE, any req: choose winner; register its addr/wdata/write onto the cache_* outputs; grant_id <= winner; cache_enable <= 1; go to ISSUE.
- ISSUE: cache_enable high for exactly this cycle; at the edge cache_enable <= 0; go to WAIT.
- WAIT: hold cache_addr/cache_write_data/cache_write stable.
  - On cache_available=1: if !cache_write, rdata[grant_id] <= cache_read_data. done[grant_id] <= 1 for both loads and stores. Go to RESP.
- RESP: done pulse is visible this cycle; at the edge done <= 0; go to IDLE.
- IDLE re-samples reqs one cycle after RESP. A requester therefore has exactly one edge after seeing done to drop req or present a new request; no double issue is possible.
- Arbitration (default, fixed): port 1 beats port 0 when both requests are high.
- Latency, cache hit: req sampled in cycle 0 -> cache_enable in cycle 1 -> cache_available in cycle 3 -> done in cycle 4.
- Latency, miss: done = cycle of cache_available + 1. No limit on WAIT duration.
- Throughput: at most one transaction per 5 cycles (hit). Back-to-back grants from the same port are allowed.
- cache_available seen in IDLE, ISSUE or RESP is ignored (stray pulse).
- Requests changing while not in IDLE have no effect; only IDLE samples req/addr/wdata/write.
- Reset mid-transaction returns to IDLE immediately and drops the outstanding transaction; no done is produced. The cache shares rstn domain sequencing at system level.
- rdata of the non-granted port is never modified.

Optional Feature:
- Macro: CACHE_PORT_ARB_RR_EN.
- Defined: round-robin arbitration. When both reqs are high in IDLE, grant the port != rr_last. rr_last updates to the winner on every grant. A single requester always wins regardless of rr_last.
- Undefined: fixed priority, port 1 over port 0. rr_last is not implemented.

Test Plan:
- Reset, then req0=1, addr0=0x0000010, write0=0; cache model hit returns 0xDEADBEEF -> cache_enable pulse in cycle 1 with cache_addr=0x0000010; done0 in cycle 4; rdata0=0xDEADBEEF; done1 stays 0.
- req1 store, addr1=0x0000024, wdata1=0x12345678, miss model with available 20 cycles after enable -> cache_write=1 and cache_write_data=0x12345678 held through WAIT; single done1 pulse; rdata1 unchanged.
- req0 and req1 both held for 4 transactions, macro undefined -> grants 1,1,1,1; port 0 starved. With CACHE_PORT_ARB_RR_EN -> grants 0,1,0,1 (rr_last=1 after reset).
- Requester drops req the edge after done -> exactly one cache_enable per transaction; count of enables equals count of dones over 100 random requests.
- Assert rstn=0 during WAIT -> all outputs at reset values asynchronously; later cache_available pulse in IDLE produces no done.
- Inject cache_available in IDLE with no req -> no done, state stays IDLE, busy=0.
